carbonio_uart_tx_arb: RTL and testbench

- Round-robin arbiter that shares the CarbonIO UART TX FIFO push port (tx_push/tx_data) between N_REQ byte-stream requesters, e.g. CSR path, debug monitor and DMA.
- A grant is locked for a burst: it ends on a last-flagged byte or after BURST_MAX bytes.
- Flow control is credit-based from the FIFO's tx_count, so no byte is ever pushed into a full FIFO.

---
 rtl/carbonio_uart_arb_pkg.sv | 23 ++
 rtl/carbonio_rr_pick.sv | 30 +++
 rtl/carbonio_uart_tx_arb.sv | 139 +++++++++++++
 tb/tb_carbonio_uart_tx_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carbonio_uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : carbonio_uart_arb_pkg
// Brief    : Shared types and helpers for the CarbonIO UART TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package carbonio_uart_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int BYTE_W      = 8;
    localparam int BURST_CNT_W = 8;

    // A single requester still needs a one-bit index so the port never collapses.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : carbonio_uart_arb_pkg
`default_nettype wire

// File: rtl/carbonio_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : carbonio_rr_pick
// Brief    : Combinational rotate-priority picker; first set request at or
//            after i_start, wrapping modulo N_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module carbonio_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_found && i_req[(int'(i_start) + k) % N_REQ]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'((int'(i_start) + k) % N_REQ);
            end
        end
    end

endmodule : carbonio_rr_pick
`default_nettype wire

// File: rtl/carbonio_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : carbonio_uart_tx_arb
// Brief    : Round-robin burst arbiter feeding the CarbonIO UART TX FIFO push
//            port with credit-based flow control from tx_count.
// Revision : 1.0 - initial release
// ============================================================================
module carbonio_uart_tx_arb
    import carbonio_uart_arb_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int BURST_MAX = 8,
    parameter  int TX_DEPTH  = 64,
    localparam int IDX_W     = idx_width(N_REQ),
    localparam int TC_W      = $clog2(TX_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [TC_W-1:0]           tx_count,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*BYTE_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_push,
    output logic [BYTE_W-1:0]         tx_data,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy
);

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        w_rr_nxt;
    logic [IDX_W-1:0]        r_grant_id;
    logic [IDX_W-1:0]        w_gid_nxt;
    logic [BURST_CNT_W-1:0]  r_burst_cnt;
    logic [BURST_CNT_W-1:0]  w_cnt_nxt;
    logic                    r_tx_push;
    logic                    w_push_nxt;
    logic [BYTE_W-1:0]       r_tx_data;
    logic [BYTE_W-1:0]       w_data_nxt;

    logic [BYTE_W-1:0]       w_bytes [N_REQ];
    logic                    w_found;
    logic [IDX_W-1:0]        w_pick_idx;
    logic [TC_W:0]           w_credit_sum;
    logic                    w_space_ok;
    logic                    w_sel_valid;
    logic                    w_sel_last;
    logic                    w_accept;
    logic                    w_burst_end;
    logic [IDX_W-1:0]        w_gid_inc;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_bytes[gi] = req_data[gi*BYTE_W +: BYTE_W];
    end

    carbonio_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_start (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    // tx_count lags our own registered push by a cycle, so count it as used.
    assign w_credit_sum = {1'b0, tx_count} + {{TC_W{1'b0}}, r_tx_push};
    assign w_space_ok   = w_credit_sum < (TC_W+1)'(TX_DEPTH);

    assign w_sel_valid  = req_valid[r_grant_id];
    assign w_sel_last   = req_last[r_grant_id];
    assign w_accept     = (r_state == ARB_GRANT) && enable && w_space_ok && w_sel_valid;
    assign w_burst_end  = w_sel_last || (r_burst_cnt == BURST_CNT_W'(BURST_MAX - 1));
    assign w_gid_inc    = (r_grant_id == IDX_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_gid_nxt   = r_grant_id;
        w_cnt_nxt   = r_burst_cnt;
        w_push_nxt  = 1'b0;
        w_data_nxt  = r_tx_data;
        req_ready   = '0;
        case (r_state)
            ARB_IDLE: begin
                if (enable && w_found) begin
                    w_state_nxt = ARB_GRANT;
                    w_gid_nxt   = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            ARB_GRANT: begin
                if (!enable) begin
                    w_state_nxt = ARB_IDLE;
                end else begin
                    req_ready[r_grant_id] = w_space_ok;
                    if (w_accept) begin
                        w_push_nxt = 1'b1;
                        w_data_nxt = w_bytes[r_grant_id];
                        w_cnt_nxt  = r_burst_cnt + 1'b1;
                        if (w_burst_end) begin
                            w_state_nxt = ARB_IDLE;
                            w_rr_nxt    = w_gid_inc;
                        end
                    end
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
            r_tx_push   <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_grant_id  <= w_gid_nxt;
            r_burst_cnt <= w_cnt_nxt;
            r_tx_push   <= w_push_nxt;
            r_tx_data   <= w_data_nxt;
        end
    end

    assign tx_push  = r_tx_push;
    assign tx_data  = r_tx_data;
    assign grant_id = r_grant_id;
    assign busy     = (r_state == ARB_GRANT);

endmodule : carbonio_uart_tx_arb
`default_nettype wire

// File: tb/tb_carbonio_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_carbonio_uart_tx_arb
// Brief    : Directed vector table plus handshake-driven stream sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_carbonio_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [6:0]  tx_count = '0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_push;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;

    carbonio_uart_tx_arb #(
        .N_REQ     (4),
        .BURST_MAX (8),
        .TX_DEPTH  (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .tx_count  (tx_count),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_push   (tx_push),
        .tx_data   (tx_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        logic [6:0] tc;
        logic [3:0] v;
        logic [3:0] l;
        logic [3:0] e_rdy;
        logic       e_push;
        logic [7:0] e_data;
        logic [1:0] e_gid;
        logic       e_busy;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    function automatic vec_t mk(bit rst, bit en, logic [6:0] tc, logic [3:0] v, logic [3:0] l,
                                logic [3:0] r, logic p, logic [7:0] d, logic [1:0] g, logic b);
        vec_t x;
        x.rst = rst; x.en = en; x.tc = tc; x.v = v; x.l = l;
        x.e_rdy = r; x.e_push = p; x.e_data = d; x.e_gid = g; x.e_busy = b;
        return x;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        enable    = 1'b1;
        req_valid = '0;
        req_last  = '0;
        tx_count  = '0;
        #1;
        chk("rst tx_push", 32'(tx_push), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst grant_id", 32'(grant_id), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Stream bookkeeping shared between the stream task and the test body.
    logic [7:0] byte_q [$];
    int         burst_gid [$];
    int         burst_len [$];
    int         idle_mid;
    logic       busy_log [256];
    logic       push_log [256];
    logic [3:0] rdy_log  [256];

    task automatic stream(input int len [4], input int off_from, input int off_to, input int budget);
        int  ptr [4];
        int  cyc;
        int  cur_len;
        int  cur_gid;
        bit  started;
        bit  done;
        bit  rem;
        logic [3:0] acc;
        ptr = '{default: 0};
        byte_q.delete();
        burst_gid.delete();
        burst_len.delete();
        idle_mid = 0;
        cyc = 0; cur_len = 0; cur_gid = 0; started = 0; done = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            enable = !(cyc >= off_from && cyc <= off_to);
            for (int i = 0; i < 4; i++) begin
                req_valid[i]         = ptr[i] < len[i];
                req_data[8*i +: 8]   = 8'(i*32 + ptr[i]);
                req_last[i]          = (ptr[i] == len[i] - 1);
            end
            #1;
            busy_log[cyc] = busy;
            push_log[cyc] = tx_push;
            rdy_log[cyc]  = req_ready;
            if (tx_push) byte_q.push_back(tx_data);
            acc = req_valid & req_ready;
            rem = 0;
            for (int i = 0; i < 4; i++) if (ptr[i] < len[i]) rem = 1;
            if (!busy && cur_len > 0) begin
                burst_gid.push_back(cur_gid);
                burst_len.push_back(cur_len);
                cur_len = 0;
            end
            if (!busy && started && rem) idle_mid++;
            done = !rem && !tx_push && !busy && (acc == 0);
            if (acc != 0) begin
                chk("accept onehot", 32'($onehot(acc)), 32'd1);
                started = 1;
                cur_gid = int'(grant_id);
                cur_len++;
                for (int i = 0; i < 4; i++) if (acc[i]) ptr[i]++;
            end
            cyc++;
        end
        chk("stream completed in budget", 32'(done), 32'd1);
        req_valid = '0;
        req_last  = '0;
        enable    = 1'b1;
    endtask

    task automatic chk_bytes(input string nm, input int exp [$]);
        chk({nm, " byte count"}, 32'(byte_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < byte_q.size(); i++)
            chk($sformatf("%s byte %0d", nm, i), 32'(byte_q[i]), 32'(exp[i]));
    endtask

    task automatic chk_bursts(input string nm, input int eg [$], input int el [$]);
        chk({nm, " burst count"}, 32'(burst_len.size()), 32'(el.size()));
        for (int i = 0; i < el.size() && i < burst_len.size(); i++) begin
            chk($sformatf("%s burst %0d gid", nm, i), 32'(burst_gid[i]), 32'(eg[i]));
            chk($sformatf("%s burst %0d len", nm, i), 32'(burst_len[i]), 32'(el[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_b [$];
        int exp_g [$];
        int exp_l [$];
        int len [4];

        // Alternating 0,2 grants, then credit and enable boundaries on requester 0.
        vt[0]  = mk(1, 1, 7'd0,  4'b0101, 4'b1111, 4'b0000, 0, 8'h00, 2'd0, 0);
        vt[1]  = mk(0, 1, 7'd0,  4'b0101, 4'b1111, 4'b0001, 0, 8'h00, 2'd0, 1);
        vt[2]  = mk(0, 1, 7'd0,  4'b0101, 4'b1111, 4'b0000, 1, 8'hA0, 2'd0, 0);
        vt[3]  = mk(0, 1, 7'd0,  4'b0101, 4'b1111, 4'b0100, 0, 8'hA0, 2'd2, 1);
        vt[4]  = mk(0, 1, 7'd0,  4'b0101, 4'b1111, 4'b0000, 1, 8'hA2, 2'd2, 0);
        vt[5]  = mk(0, 1, 7'd0,  4'b0101, 4'b1111, 4'b0001, 0, 8'hA2, 2'd0, 1);
        vt[6]  = mk(0, 1, 7'd0,  4'b0101, 4'b1111, 4'b0000, 1, 8'hA0, 2'd0, 0);
        vt[7]  = mk(0, 1, 7'd0,  4'b0101, 4'b1111, 4'b0100, 0, 8'hA0, 2'd2, 1);
        vt[8]  = mk(0, 1, 7'd0,  4'b0101, 4'b1111, 4'b0000, 1, 8'hA2, 2'd2, 0);
        vt[9]  = mk(1, 1, 7'd63, 4'b0001, 4'b0000, 4'b0000, 0, 8'h00, 2'd0, 0);
        vt[10] = mk(0, 1, 7'd63, 4'b0001, 4'b0000, 4'b0001, 0, 8'h00, 2'd0, 1);
        vt[11] = mk(0, 1, 7'd63, 4'b0001, 4'b0000, 4'b0000, 1, 8'hA0, 2'd0, 1);
        vt[12] = mk(0, 1, 7'd64, 4'b0001, 4'b0000, 4'b0000, 0, 8'hA0, 2'd0, 1);
        vt[13] = mk(0, 1, 7'd64, 4'b0001, 4'b0000, 4'b0000, 0, 8'hA0, 2'd0, 1);
        vt[14] = mk(0, 1, 7'd63, 4'b0001, 4'b0000, 4'b0001, 0, 8'hA0, 2'd0, 1);
        vt[15] = mk(0, 1, 7'd63, 4'b0001, 4'b0000, 4'b0000, 1, 8'hA0, 2'd0, 1);
        vt[16] = mk(0, 1, 7'd0,  4'b0001, 4'b0000, 4'b0001, 0, 8'hA0, 2'd0, 1);
        vt[17] = mk(0, 0, 7'd0,  4'b0001, 4'b0000, 4'b0000, 1, 8'hA0, 2'd0, 1);
        vt[18] = mk(0, 0, 7'd0,  4'b0001, 4'b0000, 4'b0000, 0, 8'hA0, 2'd0, 0);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].rst) do_reset();
            @(negedge clk);
            enable    = vt[i].en;
            tx_count  = vt[i].tc;
            req_valid = vt[i].v;
            req_last  = vt[i].l;
            req_data  = 32'hA3A2A1A0;
            #1;
            chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d tx_push", i),   32'(tx_push),   32'(vt[i].e_push));
            chk($sformatf("v%0d tx_data", i),   32'(tx_data),   32'(vt[i].e_data));
            chk($sformatf("v%0d grant_id", i),  32'(grant_id),  32'(vt[i].e_gid));
            chk($sformatf("v%0d busy", i),      32'(busy),      32'(vt[i].e_busy));
        end

        // Requester 1 streams 20 bytes: bursts 8, 8, 4.
        do_reset();
        len = '{0, 20, 0, 0};
        stream(len, -1, -1, 200);
        exp_b.delete();
        for (int k = 0; k < 20; k++) exp_b.push_back(32 + k);
        chk_bytes("single", exp_b);
        exp_g = '{1, 1, 1};
        exp_l = '{8, 8, 4};
        chk_bursts("single", exp_g, exp_l);
        chk("single idle gaps", 32'(idle_mid), 32'd2);

        // Requesters 1 and 3 with 10-byte messages alternate 8,8,2,2.
        do_reset();
        len = '{0, 10, 0, 10};
        stream(len, -1, -1, 200);
        exp_b.delete();
        for (int k = 0; k < 8; k++) exp_b.push_back(32 + k);
        for (int k = 0; k < 8; k++) exp_b.push_back(96 + k);
        exp_b.push_back(40); exp_b.push_back(41);
        exp_b.push_back(104); exp_b.push_back(105);
        chk_bytes("dual", exp_b);
        exp_g = '{1, 3, 1, 3};
        exp_l = '{8, 8, 2, 2};
        chk_bursts("dual", exp_g, exp_l);
        chk("dual idle gaps", 32'(idle_mid), 32'd3);

        // Enable dropped for three cycles in the middle of requester 2's burst.
        do_reset();
        len = '{0, 0, 6, 0};
        stream(len, 3, 5, 200);
        exp_b.delete();
        for (int k = 0; k < 6; k++) exp_b.push_back(64 + k);
        chk_bytes("enoff", exp_b);
        chk("enoff ready c3", 32'(rdy_log[3]), 32'd0);
        chk("enoff ready c4", 32'(rdy_log[4]), 32'd0);
        chk("enoff ready c5", 32'(rdy_log[5]), 32'd0);
        chk("enoff busy c3", 32'(busy_log[3]), 32'd1);
        chk("enoff busy c4", 32'(busy_log[4]), 32'd0);
        chk("enoff busy c5", 32'(busy_log[5]), 32'd0);
        chk("enoff push c3", 32'(push_log[3]), 32'd1);
        chk("enoff push c4", 32'(push_log[4]), 32'd0);
        chk("enoff push c5", 32'(push_log[5]), 32'd0);
        chk("enoff regrant busy c7", 32'(busy_log[7]), 32'd1);
        chk("enoff regrant ready c7", 32'(rdy_log[7]), 32'b0100);

        // Reset asserted while a push is in flight mid-burst of requester 3.
        do_reset();
        enable    = 1'b1;
        tx_count  = '0;
        req_data  = 32'hA3A2A1A0;
        req_valid = 4'b1010;
        req_last  = 4'b0010;
        repeat (5) @(negedge clk);
        #1;
        chk("midrst pre push", 32'(tx_push), 32'd1);
        chk("midrst pre busy", 32'(busy), 32'd1);
        chk("midrst pre gid", 32'(grant_id), 32'd3);
        chk("midrst pre data", 32'(tx_data), 32'hA3);
        rst_n = 1'b0;
        #1;
        chk("midrst push", 32'(tx_push), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst gid", 32'(grant_id), 32'd0);
        chk("midrst ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("postrst gid", 32'(grant_id), 32'd1);
        chk("postrst busy", 32'(busy), 32'd1);
        chk("postrst ready", 32'(req_ready), 32'b0010);
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_carbonio_uart_tx_arb
`default_nettype wire
